benes_sched_ctrl: RTL and testbench

Scheduler and configurator for the 32-port Benes permutation datapath used in the CNN data-routing path. It holds a small table of 9-bit switch-select words and accepts 4-word input frames from an upstream requester over a valid/ready handshake. For each frame it drives the network inputs together with the next scheduled select word. It tracks the network's fixed latency so it can tag returning outputs as valid, and it signals job completion.

---
 rtl/benes_pkg.sv | 40 ++++
 rtl/benes_sel_table.sv | 30 +++
 rtl/benes_sched_ctrl.sv | 135 +++++++++++++
 tb/tb_benes_sched_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/benes_pkg.sv
// Shared definitions for the Benes permutation scheduler.
// Holds the datapath and table dimensions, the network latency, the
// controller state encoding, the select-word field layout and the
// schedule-index step helper.
package benes_pkg;

  localparam int N      = 32;
  localparam int DEPTH  = 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int LAT    = 2;

  // Select word layout: sf | s16[7] | sl
  localparam int SF_BIT  = 8;
  localparam int SL_BIT  = 0;
  localparam int B32     = SF_BIT + 1;
  localparam int S16_MSB = SF_BIT - 1;
  localparam int S16_LSB = SL_BIT + 1;

  typedef struct packed {
    logic                 sf;
    logic [S16_MSB:S16_LSB] s16;
    logic                 sl;
  } sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Advance the rotation index; a rotation of 0 or 1 entries pins it at 0.
  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx,
                                             input logic [AW:0]   len);
    if (len <= (AW+1)'(1))              return '0;
    if ({1'b0, idx} == len - 1'b1)      return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/benes_sel_table.sv
// Select-word register file for the Benes scheduler.
// DEPTH x B32 entries, cleared by the asynchronous reset, one synchronous
// write port and one combinational read port.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   we/waddr/wdata  write strobe, address, select word
//   raddr/rdata     combinational read
module benes_sel_table import benes_pkg::*; (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [B32-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [B32-1:0] rdata
);

  logic [B32-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/benes_sched_ctrl.sv
// Scheduler / configurator for the 32-port Benes routing network.
// Accepts 4-word frames over valid/ready, registers them onto the network
// inputs together with the next select word from a rotating table, tracks
// the network latency to tag returning words and pulses done at job end.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   cfg_we/cfg_addr/cfg_data   table write (honoured only while idle)
//   sched_len, frame_cnt       rotation length and frames per job (sampled on start)
//   start                      job start pulse
//   in_valid/in_ready, in_d*   upstream frame handshake and words
//   net_x*, net_s              network inputs and select word
//   net_y*                     network outputs
//   out_valid, out_d*          routed frame tag and words
//   busy, done, cfg_err        status
module benes_sched_ctrl import benes_pkg::*; (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [B32-1:0] cfg_data,
  input  logic [AW:0]    sched_len,
  input  logic [15:0]    frame_cnt,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_d0,
  input  logic [N-1:0]   in_d1,
  input  logic [N-1:0]   in_d2,
  input  logic [N-1:0]   in_d3,
  output logic [N-1:0]   net_x0,
  output logic [N-1:0]   net_x1,
  output logic [N-1:0]   net_x2,
  output logic [N-1:0]   net_x3,
  output logic [B32-1:0] net_s,
  input  logic [N-1:0]   net_y0,
  input  logic [N-1:0]   net_y1,
  input  logic [N-1:0]   net_y2,
  input  logic [N-1:0]   net_y3,
  output logic           out_valid,
  output logic [N-1:0]   out_d0,
  output logic [N-1:0]   out_d1,
  output logic [N-1:0]   out_d2,
  output logic [N-1:0]   out_d3,
  output logic           busy,
  output logic           done,
  output logic           cfg_err
);

  state_t         state_q, state_d;
  logic [15:0]    fc_q;
  logic [15:0]    cnt_q;
  logic [AW:0]    len_q;
  logic [AW-1:0]  idx_q;
  logic [B32-1:0] tbl_rd;
  logic           accept;
  logic           last_acc;
  // vld_p[0] is aligned with the frame sitting on net_x; each further bit
  // is one cycle of network latency, so vld_p[LAT] tags net_y.
  logic [LAT:0]   vld_p;

  benes_sel_table u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we && (state_q == IDLE)),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_q),
    .rdata (tbl_rd)
  );

  assign in_ready  = (state_q == RUN) && (cnt_q < fc_q);
  assign accept    = in_valid && in_ready;
  assign last_acc  = accept && ((cnt_q + 16'd1) == fc_q);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign out_valid = vld_p[LAT];
  assign out_d0    = net_y0;
  assign out_d1    = net_y1;
  assign out_d2    = net_y2;
  assign out_d3    = net_y3;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (frame_cnt != 16'd0) ? RUN : FIN;
      RUN:     if (last_acc) state_d = DRAIN;
      DRAIN:   if (vld_p == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fc_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      vld_p   <= '0;
      cfg_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_err <= cfg_we && (state_q != IDLE);
      vld_p   <= {vld_p[LAT-1:0], accept};
      if ((state_q == IDLE) && start && (frame_cnt != 16'd0)) begin
        fc_q  <= frame_cnt;
        len_q <= sched_len;
        idx_q <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 16'd1;
        idx_q <= next_idx(idx_q, len_q);
      end
    end
  end

  // Stage p0: frame and select word presented to the network
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      net_x0 <= '0;
      net_x1 <= '0;
      net_x2 <= '0;
      net_x3 <= '0;
      net_s  <= '0;
    end else begin
      net_x0 <= accept ? in_d0 : '0;
      net_x1 <= accept ? in_d1 : '0;
      net_x2 <= accept ? in_d2 : '0;
      net_x3 <= accept ? in_d3 : '0;
      if (accept) net_s <= tbl_rd;
    end
  end

endmodule

// File: tb/tb_benes_sched_ctrl.sv
module tb_benes_sched_ctrl;
  import benes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic           cfg_we = 1'b0;
  logic [AW-1:0]  cfg_addr = '0;
  logic [B32-1:0] cfg_data = '0;
  logic [AW:0]    sched_len = '0;
  logic [15:0]    frame_cnt = '0;
  logic           start = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready, out_valid, busy, done, cfg_err;
  logic [B32-1:0] net_s;
  logic [N-1:0]   din [4];
  logic [N-1:0]   nx [4];
  logic [N-1:0]   od [4];
  logic [N-1:0]   y1 [4];
  logic [N-1:0]   y2 [4];

  benes_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sched_len(sched_len), .frame_cnt(frame_cnt), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_d0(din[0]), .in_d1(din[1]), .in_d2(din[2]), .in_d3(din[3]),
    .net_x0(nx[0]), .net_x1(nx[1]), .net_x2(nx[2]), .net_x3(nx[3]),
    .net_s(net_s),
    .net_y0(y2[0]), .net_y1(y2[1]), .net_y2(y2[2]), .net_y3(y2[3]),
    .out_valid(out_valid),
    .out_d0(od[0]), .out_d1(od[1]), .out_d2(od[2]), .out_d3(od[3]),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  // Stand-in network: two-cycle latency, reverses word order.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      y1[i] <= nx[3-i];
      y2[i] <= y1[i];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model (event/time based) ----------------
  int cyc = 0;
  bit job = 0;
  int fc = 0, len = 0, n = 0, fin_at = -1;
  bit [B32-1:0] mtab [DEPTH];
  bit ovld_at [4096];
  bit [N-1:0] od_at [4096][4];
  bit m_acc, m_jprev;
  bit exp_busy, exp_done, exp_ready, exp_ovld, exp_err;
  bit [B32-1:0] exp_nets;
  bit [N-1:0] exp_nx [4];
  bit [N-1:0] exp_od [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job = 0; fc = 0; len = 0; n = 0; fin_at = -1;
      foreach (mtab[i]) mtab[i] = '0;
      foreach (ovld_at[i]) ovld_at[i] = 0;
      exp_busy = 0; exp_done = 0; exp_ready = 0; exp_ovld = 0; exp_err = 0;
      exp_nets = '0;
      for (int i = 0; i < 4; i++) begin exp_nx[i] = '0; exp_od[i] = '0; end
    end else begin
      cyc++;
      m_acc   = exp_ready && in_valid;
      m_jprev = job;
      exp_err = m_jprev && cfg_we;
      if (m_jprev && fin_at == cyc - 1) job = 0;
      if (!m_jprev) begin
        if (cfg_we) mtab[cfg_addr] = cfg_data;
        if (start) begin
          job = 1; n = 0; fc = 0; fin_at = -1;
          if (frame_cnt == 16'd0) fin_at = cyc;
          else begin fc = int'(frame_cnt); len = int'(sched_len); end
        end
      end
      if (m_acc) begin
        exp_nets = mtab[(len <= 1) ? 0 : (n % len)];
        ovld_at[cyc+LAT] = 1;
        for (int i = 0; i < 4; i++) begin
          exp_nx[i] = din[i];
          od_at[cyc+LAT][i] = din[3-i];
        end
        n++;
        if (n == fc) fin_at = cyc + LAT + 2;
      end else begin
        for (int i = 0; i < 4; i++) exp_nx[i] = '0;
      end
      exp_ready = job && (n < fc);
      exp_busy  = job;
      exp_done  = job && (fin_at == cyc);
      exp_ovld  = ovld_at[cyc];
      for (int i = 0; i < 4; i++) exp_od[i] = od_at[cyc][i];
    end
  end

  // ---------------- per-cycle compare ----------------
  int cnt_done = 0, cnt_ovld = 0, cnt_err = 0, cnt_busy = 0;

  always @(negedge clk) begin
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_ovld);
    chk("cfg_err", cfg_err, exp_err);
    chk("net_s", net_s, exp_nets);
    for (int i = 0; i < 4; i++) chk($sformatf("net_x%0d", i), nx[i], exp_nx[i]);
    if (exp_ovld)
      for (int i = 0; i < 4; i++) chk($sformatf("out_d%0d", i), od[i], exp_od[i]);
    cnt_done += int'(done);
    cnt_ovld += int'(out_valid);
    cnt_err  += int'(cfg_err);
    cnt_busy += int'(busy);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int t, input int f);
    for (int i = 0; i < 4; i++) din[i] = 32'h1000_0000 * t + 32'h100 * f + i + 1;
  endtask

  task automatic start_job(input int fcv, input int lenv);
    frame_cnt = 16'(fcv);
    sched_len = (AW+1)'(lenv);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin tick(); k++; end
    chk("job_end_bound", busy, 1'b0);
  endtask

  task automatic wr(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = B32'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  int s_done, s_ovld, s_err, s_busy;
  logic [B32-1:0] seq1 [4];

  initial begin
    foreach (din[i]) din[i] = '0;
    seq1[0] = 9'h100; seq1[1] = 9'h001; seq1[2] = 9'h100; seq1[3] = 9'h001;
    tick(); tick();
    // reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_net_s", net_s, 9'h000);
    chk("rst_net_x0", nx[0], 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: rotating schedule, back-to-back frames
    wr(0, 9'h100);
    wr(1, 9'h001);
    s_done = cnt_done; s_ovld = cnt_ovld;
    start_job(4, 2);
    in_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      set_frame(1, f);
      tick();
      chk($sformatf("t1_net_s_f%0d", f), net_s, seq1[f]);
    end
    in_valid = 1'b0;
    wait_idle();
    chk("t1_ovld_cycles", cnt_ovld - s_ovld, 4);
    chk("t1_done_pulses", cnt_done - s_done, 1);

    // 2: zero-length job
    s_done = cnt_done; s_ovld = cnt_ovld; s_busy = cnt_busy;
    start_job(0, 2);
    chk("t2_done_now", done, 1'b1);
    wait_idle();
    chk("t2_busy_cycles", cnt_busy - s_busy, 1);
    chk("t2_done_pulses", cnt_done - s_done, 1);
    chk("t2_no_ovld", cnt_ovld - s_ovld, 0);

    // 3: gapped input 1,0,0,1
    start_job(2, 2);
    in_valid = 1'b1; set_frame(3, 0);
    tick();
    chk("t3_net_s_f0", net_s, 9'h100);
    chk("t3_net_x0_f0", nx[0], 32'h3000_0001);
    in_valid = 1'b0;
    tick();
    chk("t3_gap_net_x0", nx[0], 32'h0);
    chk("t3_gap_net_x3", nx[3], 32'h0);
    chk("t3_gap_net_s", net_s, 9'h100);
    tick();
    in_valid = 1'b1; set_frame(3, 1);
    tick();
    chk("t3_net_s_f1", net_s, 9'h001);
    in_valid = 1'b0;
    wait_idle();

    // 4: table write attempted mid-job
    s_err = cnt_err;
    start_job(2, 1);
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = 9'h1FF;
    in_valid = 1'b1; set_frame(4, 0);
    tick();
    cfg_we = 1'b0; set_frame(4, 1);
    tick();
    in_valid = 1'b0;
    wait_idle();
    chk("t4_err_pulses", cnt_err - s_err, 1);
    start_job(1, 1);
    in_valid = 1'b1; set_frame(4, 2);
    tick();
    in_valid = 1'b0;
    chk("t4_table0_kept", net_s, 9'h100);
    wait_idle();

    // 5: asynchronous reset mid-job
    s_done = cnt_done;
    start_job(5, 2);
    in_valid = 1'b1; set_frame(5, 0);
    tick();
    set_frame(5, 1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5_ovld_before", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_in_ready_drop", in_ready, 1'b0);
    chk("t5_out_valid_drop", out_valid, 1'b0);
    chk("t5_busy_drop", busy, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_done", cnt_done - s_done, 0);
    start_job(1, 1);
    in_valid = 1'b1; set_frame(5, 2);
    tick();
    in_valid = 1'b0;
    chk("t5_table0_cleared", net_s, 9'h000);
    wait_idle();

    // 6: sched_len 0 pins the index
    wr(0, 9'h0AA);
    start_job(3, 0);
    in_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      set_frame(6, f);
      tick();
      chk($sformatf("t6_net_s_f%0d", f), net_s, 9'h0AA);
    end
    in_valid = 1'b0;
    wait_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
